shift_add_mul_ctrl: RTL and testbench

- Multi-cycle unsigned 8x8 multiplier controller for the RISC CPU datapath.
- Sequences the existing shared 8-bit combinational adder (inputs InA/InB, output S, no carry-out) to produce a 16-bit product by shift-and-add, one bit per cycle.
- The adder is instantiated in the parent. This block drives the adder operands and consumes the sum.
- Sits beside the ALU and is started by the CPU control unit for MUL instructions.

---
 rtl/mul_pkg.sv | 12 +
 rtl/full_adder.sv | 11 +
 rtl/shift_add_mul_ctrl.sv | 91 +++++++++
 tb/tb_shift_add_mul_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared encodings and default sizes for the shift-and-add multiplier controller.
// Purely declarative: no latency, no flow control.
package mul_pkg;
  localparam int MUL_WIDTH = 8;
  localparam int MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// Shared WIDTH-bit combinational adder with no carry-out, owned by the datapath parent.
// Zero latency, no flow control.
module FullAdder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic [WIDTH-1:0] S
);
  assign S = InA + InB;
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier sequencing an external adder, one bit per cycle.
// done pulses WIDTH+1 cycles after an accepted start; start is ignored while busy.
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_s,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 carry;
  logic [2*WIDTH-1:0]   shifted;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    add_a   = '0;
    add_b   = '0;
    carry   = 1'b0;
    shifted = '0;
    case (state_q)
      S_RUN: begin
        add_a   = a_q;
        add_b   = q_q[0] ? m_q : '0;
        // The adder has no carry-out; a wrapped sum is smaller than either operand.
        carry   = q_q[0] & (add_s < a_q);
        shifted = {carry, add_s, q_q[WIDTH-1:1]};
        {a_d, q_d} = shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          prod_d  = shifted;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench for shift_add_mul_ctrl wired to the shared FullAdder.
module tb_shift_add_mul_ctrl;
  import mul_pkg::*;

  localparam int W = MUL_WIDTH;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand, mplier;
  logic [W-1:0]   add_a, add_b, add_s;
  logic           busy, done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  int lat, bcyc, n, extra;
  logic [W-1:0] a1, b1, s1, a2, s2;

  always #5 clk = ~clk;

  FullAdder #(.WIDTH(W)) u_add (
    .InA (add_a),
    .InB (add_b),
    .S   (add_s)
  );

  shift_add_mul_ctrl #(.WIDTH(W), .CNT_W(MUL_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_s        (add_s),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start one multiply, optionally pulse start again at RUN cycle index inject (0-based),
  // and count cycles until done (bounded).
  task automatic do_mul(input logic [W-1:0] m, input logic [W-1:0] q, input int inject);
    @(negedge clk);
    start = 1'b1; mcand = m; mplier = q;
    @(negedge clk);
    start = 1'b0; mcand = ~m; mplier = ~q;
    lat = 0; bcyc = 0;
    while (!done && lat < 20) begin
      if (busy) bcyc++;
      if (lat == 0) begin a1 = add_a; b1 = add_b; s1 = add_s; end
      if (lat == 1) begin a2 = add_a; s2 = add_s; end
      if (lat == inject) begin start = 1'b1; mcand = 8'h10; mplier = 8'h10; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [2*W-1:0] exp);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_busy_cycles"}, bcyc, 8);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_product"}, product, exp);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_product_held"}, product, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    #1;
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    @(negedge clk);
    rst = 1'b0;

    do_mul(8'h0D, 8'h0B, -1);
    check_op("mul_13x11", 16'h008F);

    do_mul(8'hFF, 8'hFF, -1);
    check_op("mul_ffxff", 16'hFE01);
    chk("ff_it1_add_a", a1, 8'h00);
    chk("ff_it1_add_b", b1, 8'hFF);
    chk("ff_it1_no_wrap", (s1 < a1), 0);
    chk("ff_it2_add_a", a2, 8'h7F);
    chk("ff_it2_add_s", s2, 8'h7E);
    chk("ff_it2_wrap", (s2 < a2), 1);

    do_mul(8'h00, 8'hA5, -1);
    check_op("mul_zero", 16'h0000);

    do_mul(8'h01, 8'hA5, -1);
    check_op("mul_ident", 16'h00A5);

    do_mul(8'h03, 8'h05, 2);
    check_op("start_busy", 16'h000F);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk("start_busy_no_second_op", extra, 0);

    // Back-to-back: start held high through the first operation and its DONE cycle.
    start = 1'b1; mcand = 8'h06; mplier = 8'h03;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", done, 1);
    chk("b2b_first_product", product, 16'h0012);
    mcand = 8'h02; mplier = 8'h07;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_rerun_busy", busy, 1);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_spacing", n, 9);
    chk("b2b_second_product", product, 16'h000E);

    // Reset asserted off-edge in the 4th RUN cycle.
    @(negedge clk);
    start = 1'b1; mcand = 8'h0D; mplier = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_product", product, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_add_a", add_a, 0);
    chk("rst_mid_add_b", add_b, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", extra, 0);

    do_mul(8'h12, 8'h34, -1);
    check_op("post_rst", 16'h03A8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
